// File: rtl/vector_slide_pkg.sv
// Purpose : shared types for the vector slide/rotate pipeline.
// Latency : n/a (types only).
// Backpressure: n/a.
// Contents: slide_mode_e operation encoding and a lane-vector type at the
// default datapath size. Modules with other parameter values declare their
// own lane-vector type from their own DATA_WIDTH / VECTOR_LANES.
package vector_slide_pkg;

    typedef enum logic [1:0] {
        SLIDE_UP   = 2'd0,
        SLIDE_DOWN = 2'd1,
        ROT_UP     = 2'd2,
        ROT_DOWN   = 2'd3
    } slide_mode_e;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_VECTOR_LANES = 16;

    typedef logic [DEF_VECTOR_LANES-1:0][DEF_DATA_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/vector_slide_stage.sv
// Purpose : one registered barrel step of distance DIST (up/down, with rotate wrap).
// Latency : 1 cycle.
// Backpressure: rdy_o = !vld_q || rdy_i, so an empty slot always accepts.
// Ports   : vld_i/rdy_o/*_i upstream request; vld_o/rdy_i/*_o downstream.
//           a = data being shifted, b = merge vector (passes through),
//           mask = 1 where the lane still holds data from a.
module vector_slide_stage
    import vector_slide_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int VECTOR_LANES = 16,
    parameter int DIST         = 1,
    parameter int TAG_WIDTH    = 5,
    localparam int SHIFT_W     = $clog2(VECTOR_LANES) + 1,
    localparam int VW          = VECTOR_LANES * DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld_i,
    output logic                    rdy_o,
    input  logic [1:0]              mode_i,
    input  logic [SHIFT_W-1:0]      shift_i,
    input  logic [TAG_WIDTH-1:0]    tag_i,
    input  logic [VW-1:0]           a_i,
    input  logic [VW-1:0]           b_i,
    input  logic [VECTOR_LANES-1:0] mask_i,
    output logic                    vld_o,
    input  logic                    rdy_i,
    output logic [1:0]              mode_o,
    output logic [SHIFT_W-1:0]      shift_o,
    output logic [TAG_WIDTH-1:0]    tag_o,
    output logic [VW-1:0]           a_o,
    output logic [VW-1:0]           b_o,
    output logic [VECTOR_LANES-1:0] mask_o
);

    localparam int SEL_BIT = $clog2(DIST);

    typedef logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] vec_t;

    slide_mode_e            mode_e;
    logic                   rot;
    logic                   down;
    logic                   sel;
    logic                   adv;
    vec_t                   a_in;
    vec_t                   a_d;
    vec_t                   a_q;
    logic [VECTOR_LANES-1:0] mask_d;
    logic [VECTOR_LANES-1:0] mask_q;
    logic                   vld_q;
    logic [VW-1:0]          b_q;
    logic [1:0]             mode_q;
    logic [SHIFT_W-1:0]     shift_q;
    logic [TAG_WIDTH-1:0]   tag_q;

    assign mode_e = slide_mode_e'(mode_i);
    assign rot    = (mode_e == ROT_UP) || (mode_e == ROT_DOWN);
    assign down   = (mode_e == SLIDE_DOWN) || (mode_e == ROT_DOWN);
    assign sel    = shift_i[SEL_BIT];
    assign a_in   = a_i;

    // Source lanes are elaboration constants; lanes that wrap are only kept
    // for rotates, for slides their mask bit clears so the merge picks b.
    for (genvar i = 0; i < VECTOR_LANES; i++) begin : g_lane
        localparam int UP_SRC = (i + VECTOR_LANES - DIST) % VECTOR_LANES;
        localparam int DN_SRC = (i + DIST) % VECTOR_LANES;
        localparam bit UP_KEEP = (i >= DIST);
        localparam bit DN_KEEP = (i + DIST < VECTOR_LANES);

        assign a_d[i] = !sel ? a_in[i] : (down ? a_in[DN_SRC] : a_in[UP_SRC]);
        assign mask_d[i] = !sel ? mask_i[i]
                         : down ? (mask_i[DN_SRC] & (rot | DN_KEEP))
                                : (mask_i[UP_SRC] & (rot | UP_KEEP));
    end

    assign rdy_o = !vld_q || rdy_i;
    assign adv   = vld_i && rdy_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (rdy_o) begin
            vld_q <= vld_i;
        end
    end

    // Payload only loads when a request actually moves in, never on a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            shift_q <= '0;
            tag_q   <= '0;
        end else if (adv) begin
            a_q     <= a_d;
            b_q     <= b_i;
            mask_q  <= mask_d;
            mode_q  <= mode_i;
            shift_q <= shift_i;
            tag_q   <= tag_i;
        end
    end

    assign vld_o   = vld_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign mask_o  = mask_q;
    assign mode_o  = mode_q;
    assign shift_o = shift_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/vector_slide_pipe.sv
// Purpose : slide/rotate vec_a up/down by a runtime lane count, vacated slide lanes from vec_b.
// Latency : WIDTH cycles (one registered stage per shift bit), 1 request/cycle.
// Backpressure: per-stage valid/ready slices; bubbles collapse, output held while !out_ready.
// Ports   : in_valid/in_ready + vec_a, vec_b, shift, mode, in_tag request side;
//           out_valid/out_ready + vec_out, out_tag result side; clk, async rst_n.
module vector_slide_pipe
    import vector_slide_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int VECTOR_LANES = 16,
    parameter int TAG_WIDTH    = 5,
    localparam int WIDTH       = $clog2(VECTOR_LANES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_a,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_b,
    input  logic [WIDTH:0]                     shift,
    input  logic [1:0]                         mode,
    input  logic [TAG_WIDTH-1:0]               in_tag,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_out,
    output logic [TAG_WIDTH-1:0]               out_tag
);

    localparam int VW = VECTOR_LANES * DATA_WIDTH;

    typedef logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] vec_t;

    // Index k is the input of stage k; index WIDTH is the last stage's output.
    logic                    vld_s   [WIDTH+1];
    logic                    rdy_s   [WIDTH+1];
    logic [1:0]              mode_s  [WIDTH+1];
    logic [WIDTH:0]          shift_s [WIDTH+1];
    logic [TAG_WIDTH-1:0]    tag_s   [WIDTH+1];
    logic [VW-1:0]           a_s     [WIDTH+1];
    logic [VW-1:0]           b_s     [WIDTH+1];
    logic [VECTOR_LANES-1:0] mask_s  [WIDTH+1];

    slide_mode_e mode_e;
    logic        is_slide;

    assign mode_e   = slide_mode_e'(mode);
    assign is_slide = (mode_e == SLIDE_UP) || (mode_e == SLIDE_DOWN);

    assign vld_s[0]   = in_valid;
    assign in_ready   = rdy_s[0];
    assign mode_s[0]  = mode;
    assign shift_s[0] = shift;
    assign tag_s[0]   = in_tag;
    assign a_s[0]     = vec_a;
    assign b_s[0]     = vec_b;
    // A slide of L or more lanes empties the vector entirely; the top shift
    // bit has no barrel step of its own, so it is folded into the starting
    // mask. Rotates wrap by L, so the bit is simply irrelevant for them.
    assign mask_s[0]  = (is_slide && shift[WIDTH]) ? '0 : '1;

    for (genvar k = 0; k < WIDTH; k++) begin : g_stage
        vector_slide_stage #(
            .DATA_WIDTH   (DATA_WIDTH),
            .VECTOR_LANES (VECTOR_LANES),
            .DIST         (1 << (WIDTH - 1 - k)),
            .TAG_WIDTH    (TAG_WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .vld_i   (vld_s[k]),
            .rdy_o   (rdy_s[k]),
            .mode_i  (mode_s[k]),
            .shift_i (shift_s[k]),
            .tag_i   (tag_s[k]),
            .a_i     (a_s[k]),
            .b_i     (b_s[k]),
            .mask_i  (mask_s[k]),
            .vld_o   (vld_s[k+1]),
            .rdy_i   (rdy_s[k+1]),
            .mode_o  (mode_s[k+1]),
            .shift_o (shift_s[k+1]),
            .tag_o   (tag_s[k+1]),
            .a_o     (a_s[k+1]),
            .b_o     (b_s[k+1]),
            .mask_o  (mask_s[k+1])
        );
    end

    assign rdy_s[WIDTH] = out_ready;

    // Final merge straight off the last stage's registers, so the result is
    // stable whenever that stage is stalled.
    vec_t res_a;
    vec_t res_b;
    vec_t res;

    assign res_a = a_s[WIDTH];
    assign res_b = b_s[WIDTH];

    for (genvar i = 0; i < VECTOR_LANES; i++) begin : g_merge
        assign res[i] = mask_s[WIDTH][i] ? res_a[i] : res_b[i];
    end

    assign out_valid = vld_s[WIDTH];
    assign vec_out   = res;
    assign out_tag   = tag_s[WIDTH];

    // Mode and shift are not needed after the last barrel step.
    logic unused_tail;
    assign unused_tail = ^{mode_s[WIDTH], shift_s[WIDTH]};

endmodule
